// File: rtl/wishbone_bus_arbiter.sv
// Wishbone B4 classic shared bus: round-robin arbitration between two masters,
// address decode to three slaves, and local error generation for unmapped
// addresses and unresponsive slaves.
module wishbone_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] ROM_MASK = 32'hFFFF_F000,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] RAM_MASK = 32'hFFFF_0000,
    parameter logic [ADDR_WIDTH-1:0] LED_BASE = 32'h2000_0000,
    parameter logic [ADDR_WIDTH-1:0] LED_MASK = 32'hFFFF_FFF0,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    // master 0 (instruction)
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_adr,
    input  logic [DATA_WIDTH-1:0] m0_dat_o,
    input  logic [SEL_WIDTH-1:0]  m0_sel,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_dat_i,
    // master 1 (data)
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_adr,
    input  logic [DATA_WIDTH-1:0] m1_dat_o,
    input  logic [SEL_WIDTH-1:0]  m1_sel,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_dat_i,
    // slave 0 (boot ROM)
    output logic                  s0_cyc,
    output logic                  s0_stb,
    output logic                  s0_we,
    output logic [ADDR_WIDTH-1:0] s0_adr,
    output logic [DATA_WIDTH-1:0] s0_dat_o,
    output logic [SEL_WIDTH-1:0]  s0_sel,
    input  logic                  s0_ack,
    input  logic                  s0_err,
    input  logic [DATA_WIDTH-1:0] s0_dat_i,
    // slave 1 (RAM)
    output logic                  s1_cyc,
    output logic                  s1_stb,
    output logic                  s1_we,
    output logic [ADDR_WIDTH-1:0] s1_adr,
    output logic [DATA_WIDTH-1:0] s1_dat_o,
    output logic [SEL_WIDTH-1:0]  s1_sel,
    input  logic                  s1_ack,
    input  logic                  s1_err,
    input  logic [DATA_WIDTH-1:0] s1_dat_i,
    // slave 2 (LED)
    output logic                  s2_cyc,
    output logic                  s2_stb,
    output logic                  s2_we,
    output logic [ADDR_WIDTH-1:0] s2_adr,
    output logic [DATA_WIDTH-1:0] s2_dat_o,
    output logic [SEL_WIDTH-1:0]  s2_sel,
    input  logic                  s2_ack,
    input  logic                  s2_err,
    input  logic [DATA_WIDTH-1:0] s2_dat_i
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } state_e;

    localparam logic [7:0] TimeoutM1 = 8'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic                  g0, g1;
    logic                  gcyc, gstb, gwe;
    logic [ADDR_WIDTH-1:0] gadr;
    logic [DATA_WIDTH-1:0] gdat;
    logic [SEL_WIDTH-1:0]  gsel;
    logic                  sel_rom, sel_ram, sel_led, unmapped;
    logic                  r_ack, r_err;
    logic [DATA_WIDTH-1:0] r_dat;

    // State, round-robin history, watchdog and local error registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Arbiter next state; a grant is held until its owner drops cyc
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                // tie goes to the master that did not own the bus last
                if (m0_cyc && (!m1_cyc || last_q)) begin
                    state_d = StGrant0;
                    last_d  = 1'b0;
                end else if (m1_cyc) begin
                    state_d = StGrant1;
                    last_d  = 1'b1;
                end
            end
            StGrant0: begin
                if (!m0_cyc) begin
                    if (m1_cyc) begin
                        state_d = StGrant1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGrant1: begin
                if (!m1_cyc) begin
                    if (m0_cyc) begin
                        state_d = StGrant0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Mux the granted master onto the shared bus and decode its address
    always_comb begin
        g0   = (state_q == StGrant0);
        g1   = (state_q == StGrant1);
        gcyc = 1'b0;
        gstb = 1'b0;
        gwe  = 1'b0;
        gadr = '0;
        gdat = '0;
        gsel = '0;
        if (g0) begin
            gcyc = m0_cyc;
            gstb = m0_stb;
            gwe  = m0_we;
            gadr = m0_adr;
            gdat = m0_dat_o;
            gsel = m0_sel;
        end else if (g1) begin
            gcyc = m1_cyc;
            gstb = m1_stb;
            gwe  = m1_we;
            gadr = m1_adr;
            gdat = m1_dat_o;
            gsel = m1_sel;
        end
        // first match wins: ROM, then RAM, then LED
        sel_rom  = ((gadr & ROM_MASK) == ROM_BASE);
        sel_ram  = ((gadr & RAM_MASK) == RAM_BASE) && !sel_rom;
        sel_led  = ((gadr & LED_MASK) == LED_BASE) && !sel_rom && !sel_ram;
        unmapped = !sel_rom && !sel_ram && !sel_led;
    end

    // Slave-side outputs; stb is withheld during a local error cycle
    always_comb begin
        s0_cyc   = gcyc && sel_rom;
        s1_cyc   = gcyc && sel_ram;
        s2_cyc   = gcyc && sel_led;
        s0_stb   = gcyc && gstb && sel_rom && !err_q;
        s1_stb   = gcyc && gstb && sel_ram && !err_q;
        s2_stb   = gcyc && gstb && sel_led && !err_q;
        s0_we    = gwe;
        s1_we    = gwe;
        s2_we    = gwe;
        s0_adr   = gadr;
        s1_adr   = gadr;
        s2_adr   = gadr;
        s0_dat_o = gdat;
        s1_dat_o = gdat;
        s2_dat_o = gdat;
        s0_sel   = gsel;
        s1_sel   = gsel;
        s2_sel   = gsel;
    end

    // Combinational response routing from the decoded slave to the granted master
    always_comb begin
        r_ack = 1'b0;
        r_err = 1'b0;
        r_dat = '0;
        if (sel_rom) begin
            r_ack = s0_ack;
            r_err = s0_err;
            r_dat = s0_dat_i;
        end else if (sel_ram) begin
            r_ack = s1_ack;
            r_err = s1_err;
            r_dat = s1_dat_i;
        end else if (sel_led) begin
            r_ack = s2_ack;
            r_err = s2_err;
            r_dat = s2_dat_i;
        end
        m0_ack   = g0 && r_ack;
        m0_err   = g0 && (r_err || err_q);
        m0_dat_i = g0 ? r_dat : '0;
        m1_ack   = g1 && r_ack;
        m1_err   = g1 && (r_err || err_q);
        m1_dat_i = g1 ? r_dat : '0;
    end

    // Watchdog and unmapped-address error; err_q is a one-cycle pulse
    always_comb begin
        err_d = gcyc && gstb && !r_ack && !r_err && !err_q &&
                (unmapped || (cnt_q == TimeoutM1));
        if (!(gcyc && gstb) || r_ack || r_err || err_q || err_d) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// Directed self-checking bench for wishbone_bus_arbiter (TIMEOUT set to 4).
module tb_wishbone_bus_arbiter;

    logic        clock, reset;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_dat_o, m1_adr, m1_dat_o;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_dat_i, m1_dat_i;
    logic        s0_cyc, s0_stb, s0_we, s1_cyc, s1_stb, s1_we, s2_cyc, s2_stb, s2_we;
    logic [31:0] s0_adr, s0_dat_o, s1_adr, s1_dat_o, s2_adr, s2_dat_o;
    logic [3:0]  s0_sel, s1_sel, s2_sel;
    logic        s0_ack, s0_err, s1_ack, s1_err, s2_ack, s2_err;
    logic [31:0] s0_dat_i, s1_dat_i, s2_dat_i;

    int total = 0;
    int bad   = 0;

    wishbone_bus_arbiter #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_o(m0_dat_o), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_dat_i(m0_dat_i),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_o(m1_dat_o), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_dat_i(m1_dat_i),
        .s0_cyc(s0_cyc), .s0_stb(s0_stb), .s0_we(s0_we), .s0_adr(s0_adr),
        .s0_dat_o(s0_dat_o), .s0_sel(s0_sel), .s0_ack(s0_ack), .s0_err(s0_err),
        .s0_dat_i(s0_dat_i),
        .s1_cyc(s1_cyc), .s1_stb(s1_stb), .s1_we(s1_we), .s1_adr(s1_adr),
        .s1_dat_o(s1_dat_o), .s1_sel(s1_sel), .s1_ack(s1_ack), .s1_err(s1_err),
        .s1_dat_i(s1_dat_i),
        .s2_cyc(s2_cyc), .s2_stb(s2_stb), .s2_we(s2_we), .s2_adr(s2_adr),
        .s2_dat_o(s2_dat_o), .s2_sel(s2_sel), .s2_ack(s2_ack), .s2_err(s2_err),
        .s2_dat_i(s2_dat_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // OR of every DUT output bit
    logic any_out;
    assign any_out = |{m0_ack, m0_err, m0_dat_i, m1_ack, m1_err, m1_dat_i,
                       s0_cyc, s0_stb, s0_we, s0_adr, s0_dat_o, s0_sel,
                       s1_cyc, s1_stb, s1_we, s1_adr, s1_dat_o, s1_sel,
                       s2_cyc, s2_stb, s2_we, s2_adr, s2_dat_o, s2_sel};

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat_o = 0; m0_sel = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_dat_o = 0; m1_sel = 0;
        s0_ack = 0; s0_err = 0; s0_dat_i = 0;
        s1_ack = 0; s1_err = 0; s1_dat_i = 0;
        s2_ack = 0; s2_err = 0; s2_dat_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #2;
        total++;
        if (any_out !== 1'b0) begin
            bad++; $display("FAIL reset_outputs got=%b want=0", any_out);
        end
        do_reset();
        #1;
        total++;
        if (any_out !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle got=%b want=0", any_out);
        end
    endtask

    task automatic test_rom_read();
        @(negedge clock);
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0010; m0_sel = 4'hF;
        #1;
        total++;
        if (s0_cyc !== 1'b0) begin
            bad++; $display("FAIL rd_no_grant_yet got=%b want=0", s0_cyc);
        end
        @(negedge clock);
        #1;
        total++;
        if ({s0_cyc, s0_stb, s1_cyc, s2_cyc} !== 4'b1100) begin
            bad++; $display("FAIL rd_s0_strobe got=%b want=1100", {s0_cyc, s0_stb, s1_cyc, s2_cyc});
        end
        total++;
        if (s0_adr !== 32'h0000_0010) begin
            bad++; $display("FAIL rd_s0_adr got=%h want=00000010", s0_adr);
        end
        s0_ack = 1; s0_dat_i = 32'hDEAD_BEEF;
        #1;
        total++;
        if ({m0_ack, m0_err} !== 2'b10 || m0_dat_i !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rd_m0_resp got=%b/%h want=10/deadbeef", {m0_ack, m0_err}, m0_dat_i);
        end
        total++;
        if ({m1_ack, m1_err, m1_dat_i} !== 34'd0) begin
            bad++; $display("FAIL rd_m1_quiet got=%b/%h want=00/00000000", {m1_ack, m1_err}, m1_dat_i);
        end
        @(negedge clock);
        m0_cyc = 0; m0_stb = 0; s0_ack = 0; s0_dat_i = 0;
        @(negedge clock);
        #1;
        total++;
        if (s0_cyc !== 1'b0) begin
            bad++; $display("FAIL rd_release got=%b want=0", s0_cyc);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_adr = 32'h1000_0000; m1_adr = 32'h1000_0004;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        @(negedge clock);
        #1;
        total++;
        if (s1_cyc !== 1'b1 || s1_adr !== 32'h1000_0000) begin
            bad++; $display("FAIL rr_first_m0 got=%b/%h want=1/10000000", s1_cyc, s1_adr);
        end
        m0_cyc = 0; m0_stb = 0;
        @(negedge clock);
        #1;
        total++;
        if (s1_cyc !== 1'b1 || s1_adr !== 32'h1000_0004) begin
            bad++; $display("FAIL rr_handover_m1 got=%b/%h want=1/10000004", s1_cyc, s1_adr);
        end
        m1_cyc = 0; m1_stb = 0;
        @(negedge clock);
        #1;
        total++;
        if (s1_cyc !== 1'b0) begin
            bad++; $display("FAIL rr_idle got=%b want=0", s1_cyc);
        end
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        @(negedge clock);
        #1;
        total++;
        if (s1_adr !== 32'h1000_0000) begin
            bad++; $display("FAIL rr_alternate_m0 got=%h want=10000000", s1_adr);
        end
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        @(negedge clock);
    endtask

    task automatic test_led_write();
        @(negedge clock);
        idle_inputs();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h2000_0004;
        m1_dat_o = 32'h0000_00A5; m1_sel = 4'b0001;
        @(negedge clock);
        #1;
        total++;
        if ({s2_cyc, s2_stb, s2_we, s0_cyc, s1_cyc} !== 5'b11100) begin
            bad++; $display("FAIL wr_ctrl got=%b want=11100", {s2_cyc, s2_stb, s2_we, s0_cyc, s1_cyc});
        end
        total++;
        if (s2_adr !== 32'h2000_0004 || s2_dat_o !== 32'h0000_00A5 || s2_sel !== 4'b0001) begin
            bad++; $display("FAIL wr_bus got=%h/%h/%b want=20000004/000000a5/0001", s2_adr, s2_dat_o, s2_sel);
        end
        s2_ack = 1;
        #1;
        total++;
        if ({m1_ack, m0_ack} !== 2'b10) begin
            bad++; $display("FAIL wr_ack got=%b want=10", {m1_ack, m0_ack});
        end
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
    endtask

    task automatic test_unmapped();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3000_0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            #1;
            total++;
            if ({s0_stb, s1_stb, s2_stb} !== 3'b000) begin
                bad++; $display("FAIL um_no_stb k=%0d got=%b want=000", k, {s0_stb, s1_stb, s2_stb});
            end
            total++;
            if (m1_err !== (k == 1)) begin
                bad++; $display("FAIL um_err k=%0d got=%b want=%b", k, m1_err, (k == 1));
            end
            if (k == 1) m1_stb = 0;
        end
        m1_cyc = 0;
        @(negedge clock);
    endtask

    task automatic test_timeout();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1000_0100; m0_sel = 4'hF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (k == 5) m0_stb = 1;
            #1;
            total++;
            if (m0_err !== (k == 4 || k == 9)) begin
                bad++; $display("FAIL to_err k=%0d got=%b want=%b", k, m0_err, (k == 4 || k == 9));
            end
            total++;
            if (s1_stb !== !(k == 4 || k == 9)) begin
                bad++; $display("FAIL to_stb k=%0d got=%b want=%b", k, s1_stb, !(k == 4 || k == 9));
            end
            if (k == 4 || k == 9) m0_stb = 0;
        end
        m0_cyc = 0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        idle_inputs();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h1000_0008;
        m0_adr = 32'h1000_000C;
        @(negedge clock);
        s1_ack = 1; s1_dat_i = 32'h1234_5678;
        #1;
        total++;
        if (m1_ack !== 1'b1 || m1_dat_i !== 32'h1234_5678) begin
            bad++; $display("FAIL rm_before got=%b/%h want=1/12345678", m1_ack, m1_dat_i);
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (any_out !== 1'b0) begin
            bad++; $display("FAIL rm_outputs_zero got=%b want=0", any_out);
        end
        @(negedge clock);
        reset = 1'b0;
        s1_ack = 0;
        m0_cyc = 1; m0_stb = 1;
        @(negedge clock);
        #1;
        total++;
        if (s1_cyc !== 1'b1 || s1_adr !== 32'h1000_000C) begin
            bad++; $display("FAIL rm_tie_m0 got=%b/%h want=1/1000000c", s1_cyc, s1_adr);
        end
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_round_robin();
        test_led_write();
        test_unmapped();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
